// File: rtl/char_video_generator.sv
`default_nettype none
// ============================================================================
// Module   : char_video_generator
// Brief    : 80x24 text-mode pixel generator (8x16 glyphs, blinking block
//            cursor) fed by the sync generator's counters; 4-cycle pipeline.
// Revision : 1.0  initial release
// ============================================================================
module char_video_generator #(
  parameter int COLS         = 80,
  parameter int ROWS         = 24,
  parameter int HBP          = 48,
  parameter int VBP          = 35,
  parameter int BLINK_FRAMES = 35,
  parameter int LATENCY      = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [10:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        video,
  output logic        hsync_out,
  output logic        vsync_out
);

  logic [10:0] pix_x, pix_y, row_ext;
  logic [6:0]  col;
  logic [4:0]  row;

  logic [10:0] char_addr_d, char_addr_q;
  logic [3:0]  gl1_d, gl1_q, gl2_q;
  logic [2:0]  xs1_d, xs1_q, xs2_q, xs3_q;
  logic        blank1_d, blank1_q, blank2_q, blank3_q;
  logic        txt1_d, txt1_q, txt2_q, txt3_q;
  logic        hit1_d, hit1_q, hit2_q, hit3_q;
  logic        rev3_q;
  logic        video_d, video_q;

  logic [LATENCY-1:0] hs_q, vs_q;

  logic        frame_tick;
  logic [5:0]  frame_cnt_d, frame_cnt_q;
  logic        blink_on_d, blink_on_q;

  logic        unused_pix_bits;

  // Stage 0: derive text cell coordinates; row*80 as (row<<6)+(row<<4)
  always_comb begin
    pix_x       = hc - 11'(HBP);
    pix_y       = vc - 11'(VBP);
    col         = pix_x[9:3];
    row         = pix_y[8:4];
    row_ext     = {6'd0, row};
    blank1_d    = hblank | vblank;
    txt1_d      = ~blank1_d & (row < 5'(ROWS)) & (col < 7'(COLS));
    hit1_d      = txt1_d & (col == cursor_x) & (row == cursor_y);
    char_addr_d = txt1_d ? ((row_ext << 6) + (row_ext << 4) + {4'd0, col}) : 11'd0;
    gl1_d       = pix_y[3:0];
    xs1_d       = pix_x[2:0];
  end

  assign unused_pix_bits = ^{pix_x[10], pix_y[10:9]};

  always_comb begin
    frame_tick  = (hc == 11'd0) && (vc == 11'd0);
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick) begin
      if (frame_cnt_q == 6'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = 6'd0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    video_d = (font_data[3'd7 - xs3_q] ^ rev3_q ^ (hit3_q & blink_on_q)) & txt3_q & ~blank3_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      char_addr_q <= 11'd0;
      gl1_q       <= 4'd0;
      gl2_q       <= 4'd0;
      xs1_q       <= 3'd0;
      xs2_q       <= 3'd0;
      xs3_q       <= 3'd0;
      blank1_q    <= 1'b1;
      blank2_q    <= 1'b1;
      blank3_q    <= 1'b1;
      txt1_q      <= 1'b0;
      txt2_q      <= 1'b0;
      txt3_q      <= 1'b0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      hit3_q      <= 1'b0;
      rev3_q      <= 1'b0;
      video_q     <= 1'b0;
      hs_q        <= '1;
      vs_q        <= '0;
      frame_cnt_q <= 6'd0;
      blink_on_q  <= 1'b1;
    end else begin
      char_addr_q <= char_addr_d;
      gl1_q       <= gl1_d;
      xs1_q       <= xs1_d;
      blank1_q    <= blank1_d;
      txt1_q      <= txt1_d;
      hit1_q      <= hit1_d;
      gl2_q       <= gl1_q;
      xs2_q       <= xs1_q;
      blank2_q    <= blank1_q;
      txt2_q      <= txt1_q;
      hit2_q      <= hit1_q;
      // char_data is valid this cycle, so its reverse bit joins stage 3 here
      rev3_q      <= char_data[7] & txt2_q;
      xs3_q       <= xs2_q;
      blank3_q    <= blank2_q;
      txt3_q      <= txt2_q;
      hit3_q      <= hit2_q;
      video_q     <= video_d;
      hs_q        <= {hs_q[LATENCY-2:0], hsync};
      vs_q        <= {vs_q[LATENCY-2:0], vsync};
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign char_addr = char_addr_q;
  assign font_addr = txt2_q ? {char_data[6:0], gl2_q} : 11'd0;
  assign video     = video_q;
  assign hsync_out = hs_q[LATENCY-1];
  assign vsync_out = vs_q[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_char_video_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_video_generator
// Brief    : Directed self-checking bench for char_video_generator.
// Revision : 1.0  initial release
// ============================================================================
module tb_char_video_generator;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [10:0] hc = 11'd100, vc = 11'd100;
  logic        hblank = 1'b1, vblank = 1'b0, hsync = 1'b1, vsync = 1'b0;
  logic [6:0]  cursor_x = 7'd100;
  logic [4:0]  cursor_y = 5'd31;
  logic [10:0] char_addr, font_addr;
  logic [7:0]  char_data = 8'h00, font_data = 8'h00;
  logic        video, hsync_out, vsync_out;

  logic [7:0]  cram [0:2047];
  logic [7:0]  from [0:2047];

  int n_cmp = 0;
  int n_bad = 0;

  logic        cap_vid [0:127];
  logic [10:0] cap_ca  [0:127];
  logic [10:0] cap_fa  [0:127];
  logic        cap_hs  [0:127];
  logic        cap_vs  [0:127];
  logic        drv_hs  [0:127];
  logic        drv_vs  [0:127];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    char_data <= cram[char_addr];
    font_data <= from[font_addr];
  end

  char_video_generator dut (
    .clk(clk), .clr(clr), .hc(hc), .vc(vc), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .char_addr(char_addr), .char_data(char_data), .font_addr(font_addr),
    .font_data(font_data), .video(video), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  task automatic set_in(input int h, input int v);
    hc     = 11'(h);
    vc     = 11'(v);
    hblank = (h < 48) || (h >= 688);
    vblank = (v < 35) || (v >= 435);
    hsync  = !(h >= 736);
    vsync  = (v >= 447);
  endtask

  // capture index i holds the outputs in the cycle after raster point i was driven
  task automatic run_seq(input int h0, input int v0, input int n, input int clr_at);
    int h, v;
    h = h0;
    v = v0;
    for (int i = 0; i < n; i++) begin
      set_in(h, v);
      clr       = (i == clr_at);
      drv_hs[i] = hsync;
      drv_vs[i] = vsync;
      @(posedge clk);
      #1;
      cap_vid[i] = video;
      cap_ca[i]  = char_addr;
      cap_fa[i]  = font_addr;
      cap_hs[i]  = hsync_out;
      cap_vs[i]  = vsync_out;
      h++;
      if (h == 800) begin
        h = 0;
        v = (v + 1) % 449;
      end
    end
    clr = 1'b0;
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0);
      @(posedge clk);
      #1;
      set_in(100, 100);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    set_in(100, 100);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (video !== 1'b0) begin n_bad++; $display("FAIL reset_video got %b want 0", video); end
    n_cmp++; if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b want 1", hsync_out); end
    n_cmp++; if (vsync_out !== 1'b0) begin n_bad++; $display("FAIL reset_vsync got %b want 0", vsync_out); end
    n_cmp++; if (char_addr !== 11'd0) begin n_bad++; $display("FAIL reset_char_addr got %0d want 0", char_addr); end
    n_cmp++; if (font_addr !== 11'd0) begin n_bad++; $display("FAIL reset_font_addr got %h want 0", font_addr); end
    clr = 1'b0;
  endtask

  task automatic test_first_cell;
    logic [7:0] exp;
    cursor_x = 7'd100;
    cursor_y = 5'd31;
    run_seq(48, 35, 12, -1);
    n_cmp++; if (cap_ca[0] !== 11'd0) begin n_bad++; $display("FAIL cell0_char_addr got %0d want 0", cap_ca[0]); end
    n_cmp++; if (cap_fa[1] !== 11'h410) begin n_bad++; $display("FAIL cell0_font_addr got %h want 410", cap_fa[1]); end
    n_cmp++; if (cap_ca[8] !== 11'd1) begin n_bad++; $display("FAIL cell1_char_addr got %0d want 1", cap_ca[8]); end
    exp = 8'h81;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_vid[3+i] !== exp[7-i]) begin n_bad++; $display("FAIL cell0_pixel%0d got %b want %b", i, cap_vid[3+i], exp[7-i]); end
    end
  endtask

  task automatic test_last_cell_and_blank_row;
    run_seq(680, 418, 4, -1);
    n_cmp++; if (cap_ca[0] !== 11'd1919) begin n_bad++; $display("FAIL last_char_addr got %0d want 1919", cap_ca[0]); end
    n_cmp++; if (cap_fa[1] !== 11'h41F) begin n_bad++; $display("FAIL last_font_addr got %h want 41f", cap_fa[1]); end
    run_seq(48, 419, 20, -1);
    n_cmp++; if (cap_ca[0] !== 11'd0) begin n_bad++; $display("FAIL row24_char_addr got %0d want 0", cap_ca[0]); end
    for (int i = 3; i < 20; i++) begin
      n_cmp++;
      if (cap_vid[i] !== 1'b0) begin n_bad++; $display("FAIL row24_video idx %0d got %b want 0", i, cap_vid[i]); end
    end
  endtask

  task automatic test_reverse_cursor;
    logic [7:0] exp;
    cursor_x = 7'd100;
    cursor_y = 5'd31;
    run_seq(56, 35, 12, -1);
    exp = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_vid[3+i] !== exp[7-i]) begin n_bad++; $display("FAIL reverse_pixel%0d got %b want %b", i, cap_vid[3+i], exp[7-i]); end
    end
    cursor_x = 7'd1;
    cursor_y = 5'd0;
    run_seq(56, 35, 12, -1);
    exp = 8'h81;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_vid[3+i] !== exp[7-i]) begin n_bad++; $display("FAIL rev_cursor_pixel%0d got %b want %b", i, cap_vid[3+i], exp[7-i]); end
    end
    cursor_x = 7'd2;
    run_seq(64, 35, 12, -1);
    exp = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_vid[3+i] !== exp[7-i]) begin n_bad++; $display("FAIL block_cursor_pixel%0d got %b want %b", i, cap_vid[3+i], exp[7-i]); end
    end
    cursor_x = 7'd100;
    cursor_y = 5'd31;
  endtask

  task automatic test_blink;
    logic [7:0] exp [0:3];
    int         npulse [0:3];
    exp[0] = 8'h7E; npulse[0] = 34;
    exp[1] = 8'h81; npulse[1] = 1;
    exp[2] = 8'h81; npulse[2] = 34;
    exp[3] = 8'h7E; npulse[3] = 1;
    cursor_x = 7'd0;
    cursor_y = 5'd0;
    for (int p = 0; p < 4; p++) begin
      frame_pulses(npulse[p]);
      run_seq(48, 35, 12, -1);
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (cap_vid[3+i] !== exp[p][7-i]) begin
          n_bad++;
          $display("FAIL blink_phase%0d_pixel%0d got %b want %b", p, i, cap_vid[3+i], exp[p][7-i]);
        end
      end
    end
  endtask

  task automatic test_sync_delay;
    cursor_x = 7'd100;
    run_seq(730, 100, 84, -1);
    for (int i = 3; i < 84; i++) begin
      n_cmp++;
      if (cap_hs[i] !== drv_hs[i-3]) begin n_bad++; $display("FAIL hsync_delay idx %0d got %b want %b", i, cap_hs[i], drv_hs[i-3]); end
    end
    run_seq(790, 446, 20, -1);
    for (int i = 3; i < 20; i++) begin
      n_cmp++;
      if (cap_vs[i] !== drv_vs[i-3]) begin n_bad++; $display("FAIL vsync_delay idx %0d got %b want %b", i, cap_vs[i], drv_vs[i-3]); end
    end
  endtask

  task automatic test_reset_mid_line;
    logic [7:0] exp;
    cursor_x = 7'd0;
    cursor_y = 5'd0;
    frame_pulses(35);
    run_seq(48, 35, 12, -1);
    exp = 8'h81;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_vid[3+i] !== exp[7-i]) begin n_bad++; $display("FAIL blink_off_pixel%0d got %b want %b", i, cap_vid[3+i], exp[7-i]); end
    end
    run_seq(48, 35, 20, 9);
    n_cmp++; if (cap_ca[9] !== 11'd0) begin n_bad++; $display("FAIL midrst_char_addr got %0d want 0", cap_ca[9]); end
    n_cmp++; if (cap_hs[9] !== 1'b1) begin n_bad++; $display("FAIL midrst_hsync got %b want 1", cap_hs[9]); end
    n_cmp++; if (cap_vs[9] !== 1'b0) begin n_bad++; $display("FAIL midrst_vsync got %b want 0", cap_vs[9]); end
    for (int i = 9; i < 13; i++) begin
      n_cmp++;
      if (cap_vid[i] !== 1'b0) begin n_bad++; $display("FAIL midrst_video idx %0d got %b want 0", i, cap_vid[i]); end
    end
    n_cmp++; if (cap_vid[13] !== 1'b1) begin n_bad++; $display("FAIL midrst_resume0 got %b want 1", cap_vid[13]); end
    n_cmp++; if (cap_vid[14] !== 1'b1) begin n_bad++; $display("FAIL midrst_resume1 got %b want 1", cap_vid[14]); end
    run_seq(48, 35, 12, -1);
    exp = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_vid[3+i] !== exp[7-i]) begin n_bad++; $display("FAIL midrst_blink_pixel%0d got %b want %b", i, cap_vid[3+i], exp[7-i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      cram[i] = 8'h00;
      from[i] = 8'h00;
    end
    cram[0]       = 8'h41;
    cram[1]       = 8'hC1;
    cram[1919]    = 8'h41;
    cram[1920]    = 8'h41;
    from[11'h410] = 8'h81;

    test_reset();
    test_first_cell();
    test_last_cell_and_blank_row();
    test_reverse_cursor();
    test_blink();
    test_sync_delay();
    test_reset_mid_line();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
